// File: rtl/dt_pack_if.sv
`default_nettype none
// ============================================================================
//  Module   : dt_pack_if
//  Purpose  : Control and memory-bus bundle between dt_pack and its
//             environment (start/threshold control, result-RAM read port,
//             packed-image write port).
//  Revision : 1.0  initial release
// ============================================================================
interface dt_pack_if;
   logic        start;
   logic [7:0]  threshold;
   logic        busy;
   logic        done;
   logic        res_rd;
   logic [13:0] res_addr;
   logic [7:0]  res_di;
   logic        sti_wr;
   logic [9:0]  sti_addr;
   logic [15:0] sti_do;

   // Packer side: drives the memory strobes and status.
   modport master (
      input  start, threshold, res_di,
      output busy, done, res_rd, res_addr, sti_wr, sti_addr, sti_do
   );

   // Environment side: drives the control request and returns read data.
   modport slave (
      output start, threshold, res_di,
      input  busy, done, res_rd, res_addr, sti_wr, sti_addr, sti_do
   );
endinterface
`default_nettype wire

// File: rtl/dt_pack.sv
`default_nettype none
// ============================================================================
//  Module   : dt_pack
//  Purpose  : Reads the 128x128 8-bit distance map from the result RAM,
//             thresholds each pixel to one bit and writes 16-pixel packed
//             words (bit 0 = first pixel in raster order) into the
//             1024x16 binary image memory.
//  Revision : 1.0  initial release
// ============================================================================
module dt_pack #(
   parameter int N_PIX   = 16384,
   parameter int WORD_W  = 16,
   parameter int N_WORDS = 1024
) (
   input  wire logic  clk,
   input  wire logic  reset,
   dt_pack_if.master  bus
);

   localparam int AW = $clog2(N_PIX);
   localparam int WW = $clog2(N_WORDS);
   localparam int BW = $clog2(WORD_W);

   localparam logic [AW-1:0] C_LAST_ADDR = AW'(N_PIX - 1);
   localparam logic [WW-1:0] C_LAST_WORD = WW'(N_WORDS - 1);
   localparam logic [BW-1:0] C_LAST_BIT  = BW'(WORD_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_q,    state_d;
   logic [7:0]          thr_q,      thr_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;
   logic                res_rd_q,   res_rd_d;
   logic [AW-1:0]       res_addr_q, res_addr_d;
   logic                cap_q,      cap_d;      // res_di carries a pixel this cycle
   logic [BW-1:0]       bit_cnt_q,  bit_cnt_d;
   logic [WORD_W-1:0]   shf_q,      shf_d;
   logic [WW-1:0]       wcnt_q,     wcnt_d;     // address of the next word to write
   logic                sti_wr_q,   sti_wr_d;
   logic [WW-1:0]       sti_addr_q, sti_addr_d;
   logic [WORD_W-1:0]   sti_do_q,   sti_do_d;

   // Next-state logic: read sequencer FSM plus the threshold/pack pipeline.
   always_comb begin
      state_d    = state_q;
      thr_d      = thr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      res_rd_d   = 1'b0;
      res_addr_d = res_addr_q;
      cap_d      = res_rd_q;
      bit_cnt_d  = bit_cnt_q;
      shf_d      = shf_q;
      wcnt_d     = wcnt_q;
      sti_wr_d   = 1'b0;
      sti_addr_d = sti_addr_q;
      sti_do_d   = sti_do_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d    = ST_RUN;
               thr_d      = bus.threshold;
               busy_d     = 1'b1;
               res_rd_d   = 1'b1;
               res_addr_d = '0;
            end
         end
         ST_RUN: begin
            if (res_addr_q == C_LAST_ADDR) begin
               state_d = ST_DRAIN;
            end else begin
               res_rd_d   = 1'b1;
               res_addr_d = res_addr_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            // The pipeline still holds the tail pixels; finish on the last word.
            if (sti_wr_q && (sti_addr_q == C_LAST_WORD)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Pixel capture runs one cycle behind the read strobe, independent of state.
      if (cap_q) begin
         shf_d[bit_cnt_q] = (bus.res_di >= thr_q);
         bit_cnt_d        = bit_cnt_q + 1'b1;
         if (bit_cnt_q == C_LAST_BIT) begin
            sti_wr_d   = 1'b1;
            sti_addr_d = wcnt_q;
            sti_do_d   = shf_d;
            wcnt_d     = wcnt_q + 1'b1;
         end
      end
   end

   // State and output registers; reset overrides any start or capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         thr_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         res_rd_q   <= 1'b0;
         res_addr_q <= '0;
         cap_q      <= 1'b0;
         bit_cnt_q  <= '0;
         shf_q      <= '0;
         wcnt_q     <= '0;
         sti_wr_q   <= 1'b0;
         sti_addr_q <= '0;
         sti_do_q   <= '0;
      end else begin
         state_q    <= state_d;
         thr_q      <= thr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         res_rd_q   <= res_rd_d;
         res_addr_q <= res_addr_d;
         cap_q      <= cap_d;
         bit_cnt_q  <= bit_cnt_d;
         shf_q      <= shf_d;
         wcnt_q     <= wcnt_d;
         sti_wr_q   <= sti_wr_d;
         sti_addr_q <= sti_addr_d;
         sti_do_q   <= sti_do_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.res_rd   = res_rd_q;
   assign bus.res_addr = res_addr_q;
   assign bus.sti_wr   = sti_wr_q;
   assign bus.sti_addr = sti_addr_q;
   assign bus.sti_do   = sti_do_q;

endmodule
`default_nettype wire
